// File: rtl/chkmon_pkg.sv
// chkmon_pkg: shared fail codes, FSM encoding and timer width for checkbits_monitor
package chkmon_pkg;
  localparam logic [1:0] FAIL_NONE    = 2'b00;
  localparam logic [1:0] FAIL_TIMEOUT = 2'b01;
  localparam logic [1:0] FAIL_ORDER   = 2'b10;
  localparam int TIMER_W = 32;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/chkmon_stable_filter.sv
// chkmon_stable_filter: 2-flop synchronizer plus debounce; stb pulses once per newly accepted value
module chkmon_stable_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] checkbits,
  output logic [15:0] stable_value,
  output logic        stable_valid,
  output logic        stb
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  logic [15:0] sync1, sync_q, cand;
  logic [CW-1:0] cnt, cnt_n;
  logic load;
  // cand always follows sync_q, so sync_q is the value being qualified this edge
  always_comb begin
    cnt_n = (sync_q != cand) ? CW'(1) : (cnt == CW'(STABLE_CYCLES)) ? cnt : cnt + 1'b1;
    load = (cnt_n == CW'(STABLE_CYCLES)) && (sync_q != stable_value || !stable_valid);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync_q <= '0;
      cand <= '0;
      cnt <= '0;
      stable_value <= '0;
      stable_valid <= 1'b0;
      stb <= 1'b0;
    end else begin
      sync1 <= checkbits;
      sync_q <= sync1;
      cand <= sync_q;
      cnt <= cnt_n;
      stb <= load;
      if (load) begin
        stable_value <= sync_q;
        stable_valid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/checkbits_monitor.sv
// checkbits_monitor: tracks a programmed milestone sequence on the debounced checkbits bus.
// Optional CHKMON_STRICT_ORDER_EN flags values that skip ahead in the table as an order failure.
module checkbits_monitor
  import chkmon_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 250000,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      checkbits,
  input  logic             tbl_we,
  input  logic [IDX_W-1:0] tbl_addr,
  input  logic [15:0]      tbl_data,
  input  logic [IDX_W:0]   seq_len,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [IDX_W:0]   cur_idx,
  output logic [15:0]      stable_value,
  output logic             stable_valid
);
  state_t state;
  logic [15:0] tbl [DEPTH];
  logic [TIMER_W-1:0] timer;
  logic [IDX_W:0] seq_q, len_eff;
  logic stb, hit, ooo;
  chkmon_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clock(clock), .reset(reset), .checkbits(checkbits),
    .stable_value(stable_value), .stable_valid(stable_valid), .stb(stb)
  );
  assign len_eff = (seq_len > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : seq_len;
  assign hit = stb && stable_value == tbl[cur_idx[IDX_W-1:0]];
`ifdef CHKMON_STRICT_ORDER_EN
  logic [DEPTH-1:0] later;
  for (genvar j = 0; j < DEPTH; j++) begin : g_ooo
    assign later[j] = j > int'(cur_idx) && j < int'(seq_q) && stable_value == tbl[j];
  end
  assign ooo = stb && |later;
`else
  assign ooo = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (tbl_we && !busy && int'(tbl_addr) < DEPTH) tbl[tbl_addr] <= tbl_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail_code <= FAIL_NONE;
      cur_idx <= '0;
      timer <= '0;
      seq_q <= '0;
    end else if (state != WAIT) begin
      if (start) begin
        seq_q <= len_eff;
        timer <= '0;
        cur_idx <= '0;
        fail_code <= FAIL_NONE;
        state <= (len_eff == '0) ? DONE : WAIT;
        busy <= len_eff != '0;
        done <= len_eff == '0;
        pass <= len_eff == '0;
      end
    end else if (hit) begin
      cur_idx <= cur_idx + 1'b1;
      timer <= '0;
      if (cur_idx + 1'b1 == seq_q) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
        pass <= 1'b1;
      end
    end else if (ooo || timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
      state <= DONE;
      busy <= 1'b0;
      done <= 1'b1;
      fail_code <= ooo ? FAIL_ORDER : FAIL_TIMEOUT;
    end else begin
      timer <= timer + 1'b1;
    end
  end
endmodule
